dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit that sequences all RV32I memory ops (LB/LH/LW/LBU/LHU/SB/SH/SW) onto the word-only, sync-read/sync-write Dmem.
- Sits between the core's execute stage and Dmem.
- Handles byte/halfword lane selection, sign/zero extension, read-modify-write for sub-word stores, and misalignment/range errors.
- One request in flight; valid/ready request side, single-cycle response pulse.

Parameters:
- ADDR_LIMIT, 4096: byte-address bound (1024 words); req_addr >= ADDR_LIMIT is an error.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  LSU can accept (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3 (size/sign)
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low bits used for SB/SH)
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores/errors
- resp_err  output  1  misaligned/illegal funct3/out-of-range, valid with resp_valid
- mem_load  output  1  to Dmem load
- mem_store  output  1  to Dmem store
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  full word to store
- mem_rdata  input  32  Dmem output_data, valid the cycle after mem_load, 0 otherwise

Behaviour:
- Reset (async): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_load=0, mem_store=0, mem_wdata=0, latched request cleared. req_ready=1 after reset.
- Accept on rising edge with req_valid && req_ready; latch we, funct3, addr, wdata. req_ready=0 in every non-IDLE state.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is an error.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0. Also an error.
- FSM states IDLE, READ, CAPTURE, WRITE, RESP:
  - IDLE: on accept → RESP with err=1 if error. Otherwise → WRITE for SW, → READ for loads/SB/SH.
  - READ: mem_load=1, mem_addr=latched word addr. → CAPTURE.
  - CAPTURE: sample mem_rdata.
    - Load: resp_rdata <= extracted lane, sign- or zero-extended per funct3. → RESP.
    - SB/SH: merge buffer <= mem_rdata with lane addr[1:0] (byte) or addr[1] (half) replaced by wdata[7:0]/[15:0]. → WRITE.
  - WRITE: mem_store=1, mem_wdata = req_wdata (SW) or merge buffer (SB/SH). → RESP.
  - RESP: resp_valid=1 for exactly one cycle. → IDLE. A new request can be accepted the following cycle.
- Latency (accept edge = cycle 0, resp_valid cycle):
  - error: 1
  - SW: 2
  - loads: 3
  - SB/SH: 4
- Errors never assert mem_load/mem_store.
- mem_load/mem_store are never both high; both low outside READ/WRITE.
- resp_rdata/resp_err hold until the next RESP. Both are zeroed at accept.
- Reset mid-operation: FSM returns to IDLE immediately; no resp_valid. If rst is asserted before the WRITE-cycle edge, no store occurs. A partial RMW never writes.
- req_* changes after accept are ignored (latched copy used).

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → SW resp cycle 2, err=0; LW resp cycle 3 rdata=0xDEADBEEF.
- SB addr 0x11 data 0x55 over 0xDEADBEEF, then LW 0x10 → mem_store at cycle 3 with mem_wdata=0xDEAD55EF; LW returns 0xDEAD55EF.
- Word 0x20=0x0000_8080:
  - LB 0x20 → 0xFFFFFF80
  - LBU 0x20 → 0x00000080
  - LH 0x20 → 0xFFFF8080
  - LHU 0x22 → 0x00000000
- LH 0x03, SW 0x06, funct3=011, LW 0x1000 → each resp_err=1 at cycle 1, rdata=0, mem_load/mem_store never asserted.
- SH 0x30 data 0x1234 with rst pulsed during CAPTURE → no mem_store, no resp_valid, req_ready=1 after reset, word 0x30 unchanged on readback.
- Back-to-back: req_valid held high with 3 LW requests → accepts spaced 4 cycles apart (3-cycle latency + IDLE), req_ready low in between, three resp_valid pulses in order.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-only, sync-read/sync-write Dmem.
// Handles RV32I lane select, sign/zero extension, sub-word read-modify-write and request errors.
module dmem_lsu #(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_load,
    output logic        mem_store,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_load_q, mem_load_d;
    logic        mem_store_q, mem_store_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_error;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        f3_ok = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >= LIMIT);
        req_error = !f3_ok || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane merge for SB/SH, both off the captured Dmem word.
    always_comb begin
        lane_b = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = 32'h0;
        endcase
        merged = mem_rdata;
        if (funct3_q[0]) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d         = req_we;
                    funct3_d     = req_funct3;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata[15:0];
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (req_error) begin
                        resp_err_d = 1'b1;
                        state_d    = S_RESP;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        mem_wdata_d = req_wdata;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (we_q) begin
                    mem_wdata_d = merged;
                    state_d     = S_WRITE;
                end else begin
                    resp_rdata_d = load_ext;
                    state_d      = S_RESP;
                end
            end
            S_WRITE:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        resp_valid_d = (state_d == S_RESP);
        mem_load_d   = (state_d == S_READ);
        mem_store_d  = (state_d == S_WRITE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_load_q   <= 1'b0;
            mem_store_q  <= 1'b0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_load_q   <= mem_load_d;
            mem_store_q  <= mem_store_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_load   = mem_load_q;
    assign mem_store  = mem_store_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed plan plus random ops against a byte-array reference memory.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_load, mem_store;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] dmem [0:1023];
    logic [7:0]  ref_b [0:4095];

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_LIMIT(4096)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_load(mem_load), .mem_store(mem_store), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Dmem: word-only, synchronous read and write; read data is zero unless a load was issued.
    always @(posedge clk) begin
        if (mem_store) dmem[mem_addr[11:2]] <= mem_wdata;
        mem_rdata <= mem_load ? dmem[mem_addr[11:2]] : 32'h0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        if (a >= 32'd4096) return 1'b1;
        return (a % op_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = op_size(f3);
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 1);
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFC;
        return {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < op_size(f3); i++) ref_b[a + i] = d[8 * i +: 8];
    endtask

    // One request; rst_at > 0 pulses reset at that cycle and expects the op to vanish.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int rst_at, input string tag);
        logic        err;
        int          lat, wait_c, n_ld, n_st, n_rsp, rsp_c, st_c, n_both;
        logic [31:0] exp_rd, exp_w, st_data, rsp_data;
        logic        rsp_err;
        err = model_err(we, f3, a);
        lat = err ? 1 : (we ? ((f3 == 3'd2) ? 2 : 4) : 3);
        exp_rd = (!err && !we) ? model_load(f3, a) : 32'h0;
        exp_w = 32'h0;
        if (!err && we && rst_at == 0) begin
            model_store(f3, a, d);
            exp_w = ref_word(a);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        wait_c = 0;
        while (!req_ready && wait_c < 10) begin
            @(negedge clk);
            wait_c++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n_ld = 0; n_st = 0; n_rsp = 0; rsp_c = 0; st_c = 0; n_both = 0;
        st_data = 0; rsp_data = 0; rsp_err = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_load) n_ld++;
            if (mem_store) begin n_st++; st_c = c; st_data = mem_wdata; end
            if (mem_load && mem_store) n_both++;
            if (resp_valid) begin n_rsp++; rsp_c = c; rsp_data = resp_rdata; rsp_err = resp_err; end
            if (rst_at == 0 && c == 1 && lat > 1) begin
                chk({tag, " rdata cleared"}, resp_rdata, 32'h0);
                chk({tag, " err cleared"}, 32'(resp_err), 32'h0);
            end
            if (rst_at == 0 && c == lat + 1) chk({tag, " rdata hold"}, resp_rdata, exp_rd);
            if (rst_at != 0 && c == rst_at) rst = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) rst = 1'b0;
        end
        chk({tag, " both"}, 32'(n_both), 32'd0);
        if (rst_at != 0) begin
            chk({tag, " no resp"}, 32'(n_rsp), 32'd0);
            chk({tag, " no store"}, 32'(n_st), 32'd0);
            chk({tag, " ready after rst"}, 32'(req_ready), 32'd1);
        end else begin
            chk({tag, " resp count"}, 32'(n_rsp), 32'd1);
            chk({tag, " latency"}, 32'(rsp_c), 32'(lat));
            chk({tag, " err"}, 32'(rsp_err), 32'(err));
            chk({tag, " rdata"}, rsp_data, exp_rd);
            chk({tag, " loads"}, 32'(n_ld), (err || (we && f3 == 3'd2)) ? 32'd0 : 32'd1);
            chk({tag, " stores"}, 32'(n_st), (err || !we) ? 32'd0 : 32'd1);
            if (!err && we) begin
                chk({tag, " store cycle"}, 32'(st_c), 32'(lat - 1));
                chk({tag, " store data"}, st_data, exp_w);
            end
        end
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f3;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp  [3];
        int          acc_c [3];
        int          n_acc, n_resp_b2b;
        for (int w = 0; w < 1024; w++) begin
            d = $urandom;
            dmem[w] = d;
            for (int i = 0; i < 4; i++) ref_b[4 * w + i] = d[8 * i +: 8];
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset rdata", resp_rdata, 32'h0);
        chk("reset err", 32'(resp_err), 32'd0);
        chk("reset mem_load", 32'(mem_load), 32'd0);
        chk("reset mem_store", 32'(mem_store), 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'h0);

        run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, "sw10");
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10");
        chk("lw10 const", ref_word(32'h10), 32'hDEADBEEF);
        run_op(1'b1, 3'b000, 32'h11, 32'h55, 0, "sb11");
        chk("sb11 const", ref_word(32'h10), 32'hDEAD55EF);
        run_op(1'b0, 3'b010, 32'h10, 32'h0, 0, "lw10b");
        run_op(1'b1, 3'b010, 32'h20, 32'h00008080, 0, "sw20");
        run_op(1'b0, 3'b000, 32'h20, 32'h0, 0, "lb20");
        run_op(1'b0, 3'b100, 32'h20, 32'h0, 0, "lbu20");
        run_op(1'b0, 3'b001, 32'h20, 32'h0, 0, "lh20");
        run_op(1'b0, 3'b101, 32'h22, 32'h0, 0, "lhu22");
        run_op(1'b0, 3'b001, 32'h03, 32'h0, 0, "lh03");
        run_op(1'b1, 3'b010, 32'h06, 32'h12345678, 0, "sw06");
        run_op(1'b0, 3'b011, 32'h40, 32'h0, 0, "f3_011");
        run_op(1'b0, 3'b010, 32'h1000, 32'h0, 0, "lw1000");
        run_op(1'b1, 3'b001, 32'h30, 32'h1234, 2, "sh30 rst");
        run_op(1'b0, 3'b010, 32'h30, 32'h0, 0, "lw30");
        run_op(1'b1, 3'b001, 32'h32, 32'hABCD_9876, 0, "sh32");
        run_op(1'b0, 3'b001, 32'h32, 32'h0, 0, "lh32");

        for (int n = 0; n < 60; n++) begin
            f3 = 3'($urandom);
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFF8 | 32'($urandom_range(0, 3)) << 1 & 32'h6;
            run_op(1'($urandom), f3, a, $urandom, 0, "rand");
        end

        b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h30;
        for (int i = 0; i < 3; i++) b2b_exp[i] = ref_word(b2b_addr[i]);
        n_acc = 0; n_resp_b2b = 0;
        for (int i = 0; i < 3; i++) acc_c[i] = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (resp_valid) begin
                if (n_resp_b2b < 3) chk("b2b rdata", resp_rdata, b2b_exp[n_resp_b2b]);
                n_resp_b2b++;
            end
            if (req_ready) begin
                if (n_acc < 3) begin
                    req_addr = b2b_addr[n_acc];
                    acc_c[n_acc] = c;
                    n_acc++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b accepts", 32'(n_acc), 32'd3);
        chk("b2b resps", 32'(n_resp_b2b), 32'd3);
        chk("b2b gap1", 32'(acc_c[1] - acc_c[0]), 32'd4);
        chk("b2b gap2", 32'(acc_c[2] - acc_c[1]), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
